// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg
// Shared definitions for the AHB-Lite to APB3 bridge: default widths,
// AHB transfer/response codes and the bridge FSM state encoding.
package ahb2apb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_SLV = 16;
    localparam int DEF_SLV_LSB = 12;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/apb_if.sv
// apb_if
// Signal bundle between the AHB interconnect, the bridge and the APB cluster.
// Ports: hclk, hreset_n (shared clock and async active-low reset).
// Modports: ahb2apb (bridge view), tb (stimulus/peripheral view).
interface apb_if
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SLV = DEF_NUM_SLV
) (
    input logic hclk,
    input logic hreset_n
);
    logic               hsel;
    logic [ADDR_W-1:0]  haddr;
    logic [1:0]         htrans;
    logic               hwrite;
    logic [2:0]         hsize;
    logic [DATA_W-1:0]  hwdata;
    logic               hready_in;
    logic               hreadyout;
    logic               hresp;
    logic [DATA_W-1:0]  hrdata;
    logic [ADDR_W-1:0]  paddr;
    logic [NUM_SLV-1:0] psel;
    logic               penable;
    logic               pwrite;
    logic [DATA_W-1:0]  pwdata;
    logic [DATA_W-1:0]  prdata;
    logic               pready;
    logic               pslverr;

    modport ahb2apb (
        input  hclk, hreset_n, hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
               prdata, pready, pslverr,
        output hreadyout, hresp, hrdata, paddr, psel, penable, pwrite, pwdata
    );

    modport tb (
        input  hclk, hreset_n, hreadyout, hresp, hrdata, paddr, psel, penable, pwrite, pwdata,
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in, prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slv_decode.sv
// apb_slv_decode
// Turns the slave index taken from the address into a one-hot select.
// Ports: idx (slave index), psel_oh (one-hot, NUM_SLV wide).
module apb_slv_decode #(
    parameter int NUM_SLV = 16,
    parameter int IDX_W   = $clog2(NUM_SLV)
) (
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_SLV-1:0] psel_oh
);
    always_comb begin
        psel_oh      = '0;
        psel_oh[idx] = 1'b1;
    end
endmodule

// File: rtl/apb_top_wrapped.sv
// apb_top_wrapped
// Binds the bridge view of apb_if to apb_top.
// Ports: bus (apb_if.ahb2apb modport).
module apb_top_wrapped (
    apb_if.ahb2apb bus
);
    apb_top u_top (
        .hclk      (bus.hclk),
        .hreset_n  (bus.hreset_n),
        .hsel      (bus.hsel),
        .haddr     (bus.haddr),
        .htrans    (bus.htrans),
        .hwrite    (bus.hwrite),
        .hsize     (bus.hsize),
        .hwdata    (bus.hwdata),
        .hready_in (bus.hready_in),
        .hreadyout (bus.hreadyout),
        .hresp     (bus.hresp),
        .hrdata    (bus.hrdata),
        .paddr     (bus.paddr),
        .psel      (bus.psel),
        .penable   (bus.penable),
        .pwrite    (bus.pwrite),
        .pwdata    (bus.pwdata),
        .prdata    (bus.prdata),
        .pready    (bus.pready),
        .pslverr   (bus.pslverr)
    );
endmodule

// File: rtl/apb_top.sv
// apb_top
// AHB-Lite slave to APB3 master bridge. Each AHB single transfer becomes
// one APB SETUP + ACCESS pair; the slave is picked from haddr bits
// [SLV_LSB +: 4] and driven on a one-hot psel.
// Ports: hclk/hreset_n clock and async active-low reset; AHB slave side
// (hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in -> hreadyout,
// hresp, hrdata); APB master side (paddr, psel, penable, pwrite, pwdata
// -> prdata, pready, pslverr).
module apb_top
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int SLV_LSB = DEF_SLV_LSB
) (
    input  logic               hclk,
    input  logic               hreset_n,
    input  logic               hsel,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [1:0]         htrans,
    input  logic               hwrite,
    input  logic [2:0]         hsize,
    input  logic [DATA_W-1:0]  hwdata,
    input  logic               hready_in,
    output logic               hreadyout,
    output logic               hresp,
    output logic [DATA_W-1:0]  hrdata,
    output logic [ADDR_W-1:0]  paddr,
    output logic [NUM_SLV-1:0] psel,
    output logic               penable,
    output logic               pwrite,
    output logic [DATA_W-1:0]  pwdata,
    input  logic [DATA_W-1:0]  prdata,
    input  logic               pready,
    input  logic               pslverr
);
    localparam int IDX_W = $clog2(NUM_SLV);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   hrdata_q, hrdata_d;
    logic                valid_xfer, ack_ok, accept;
    logic [NUM_SLV-1:0]  psel_dec;
    logic                unused_hsize;

    // Word-only bridge: transfer size carries no information here.
    assign unused_hsize = ^hsize;

    assign valid_xfer = hsel && hready_in &&
                        ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    assign ack_ok     = (state_q == ST_ACCESS) && pready && !pslverr;
    // New address phases are only taken when the bridge is driving hreadyout
    // high for an OKAY completion or sitting idle; ERR2 drops them because the
    // master cancels after seeing ERROR.
    assign accept     = valid_xfer && ((state_q == ST_IDLE) || ack_ok);

    // Slave index comes from the latched address so psel stays stable
    // through SETUP and ACCESS.
    apb_slv_decode #(.NUM_SLV(NUM_SLV), .IDX_W(IDX_W)) u_dec (
        .idx     (paddr_q[SLV_LSB +: IDX_W]),
        .psel_oh (psel_dec)
    );

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    if (pslverr)     state_d = ST_ERR1;
                    else if (accept) state_d = ST_SETUP;
                    else             state_d = ST_IDLE;
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
        if (accept) begin
            paddr_d  = haddr;
            pwrite_d = hwrite;
        end
        // SETUP is the AHB data phase, so hwdata is valid now.
        if (state_q == ST_SETUP) pwdata_d = hwdata;
        if (ack_ok)              hrdata_d = prdata;
    end

    always_comb begin
        hreadyout = 1'b0;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_IDLE:   hreadyout = 1'b1;
            ST_ACCESS: hreadyout = ack_ok;
            ST_ERR1:   hresp     = HRESP_ERROR;
            ST_ERR2: begin
                hresp     = HRESP_ERROR;
                hreadyout = 1'b1;
            end
            default: ;
        endcase
        penable = (state_q == ST_ACCESS);
        psel    = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? psel_dec : '0;
        // Read data flows through on the completing cycle, held afterwards.
        hrdata  = ack_ok ? prdata : hrdata_q;
    end

    assign paddr  = paddr_q;
    assign pwrite = pwrite_q;
    assign pwdata = pwdata_q;
endmodule

// File: tb/tb_apb_top.sv
// tb_apb_top
// Drives AHB transfers into apb_top, plays the APB slave, and compares what
// the bridge does against expectations derived from the transfer rules:
// slave = addr[15:12], hreadyout low for 1 + wait cycles, ERROR for two cycles.
module tb_apb_top;
    logic        hclk = 1'b0;
    logic        hreset_n = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = '0;
    logic        hready_in;
    logic        hrdy_lo = 1'b0;
    logic        hreadyout, hresp;
    logic [31:0] hrdata, paddr, pwdata;
    logic [15:0] psel;
    logic        penable, pwrite;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] mem [logic [31:0]];

    always #10 hclk = ~hclk;
    // Single-slave bus: bus hready follows the bridge unless a test pulls it low.
    assign hready_in = hreadyout & ~hrdy_lo;

    apb_top dut (
        .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hready_in),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic [15:0] psel;
        logic [31:0] paddr;
        logic        pwrite, setup_pen, psel_stable;
        logic [31:0] pwdata, hrdata, hold;
        int          low, pen_cyc;
        logic        resp_done, rdy_done, e1_resp, e1_rdy, e2_resp, e2_rdy;
        logic [15:0] idle_psel;
        logic        idle_rdy, idle_pen;
    } obs_t;

    function automatic logic [15:0] onehot(input logic [31:0] a);
        logic [3:0] idx;
        idx = a[15:12];
        return 16'h1 << idx;
    endfunction

    // One AHB single transfer with the bench acting as APB slave; records
    // what the bridge showed on each phase. Checks live in the test tasks.
    task automatic ahb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                            input int waits, input logic err, input logic [31:0] rd,
                            output obs_t o);
        o = '{default: '0};
        @(negedge hclk); hsel = 1; htrans = 2'b10; haddr = a; hwrite = wr; pready = 0; pslverr = 0;
        @(negedge hclk); hsel = 0; htrans = 2'b00; hwdata = wd; #1;
        o.psel = psel; o.paddr = paddr; o.pwrite = pwrite; o.setup_pen = penable;
        o.psel_stable = 1'b1;
        if (!hreadyout) o.low++;
        for (int n = 0; n <= waits; n++) begin
            @(negedge hclk); pready = (n == waits); pslverr = err && (n == waits); prdata = rd; #1;
            if (penable) o.pen_cyc++;
            if (psel !== o.psel) o.psel_stable = 1'b0;
            if (n == 0) o.pwdata = pwdata;
            if (!hreadyout) o.low++;
            if (n == waits) begin o.hrdata = hrdata; o.resp_done = hresp; o.rdy_done = hreadyout; end
        end
        @(negedge hclk); pready = 0; pslverr = 0; prdata = $urandom; #1;
        if (err) begin
            o.e1_resp = hresp; o.e1_rdy = hreadyout;
            // Address phase offered during the second ERROR cycle must be dropped.
            @(negedge hclk); hsel = 1; htrans = 2'b10; haddr = a ^ 32'h0000_5000; #1;
            o.e2_resp = hresp; o.e2_rdy = hreadyout;
            @(negedge hclk); hsel = 0; htrans = 2'b00; #1;
        end
        o.idle_psel = psel; o.idle_rdy = hreadyout; o.idle_pen = penable; o.hold = hrdata;
    endtask

    task automatic test_reset();
        #205;
        nvec++; if (hreadyout !== 1'b1) begin nerr++; $display("FAIL rst_hreadyout got %b exp 1", hreadyout); end
        nvec++; if (hresp !== 1'b0) begin nerr++; $display("FAIL rst_hresp got %b exp 0", hresp); end
        nvec++; if (hrdata !== 32'h0) begin nerr++; $display("FAIL rst_hrdata got %h exp 0", hrdata); end
        nvec++; if (paddr !== 32'h0) begin nerr++; $display("FAIL rst_paddr got %h exp 0", paddr); end
        nvec++; if (psel !== 16'h0) begin nerr++; $display("FAIL rst_psel got %h exp 0", psel); end
        nvec++; if (penable !== 1'b0) begin nerr++; $display("FAIL rst_penable got %b exp 0", penable); end
        nvec++; if (pwrite !== 1'b0) begin nerr++; $display("FAIL rst_pwrite got %b exp 0", pwrite); end
        nvec++; if (pwdata !== 32'h0) begin nerr++; $display("FAIL rst_pwdata got %h exp 0", pwdata); end
        @(negedge hclk); hreset_n = 1'b1;
    endtask

    task automatic test_single_write();
        obs_t o;
        ahb_xfer(32'h0000_B010, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0, o);
        nvec++; if (o.psel !== 16'h0800) begin nerr++; $display("FAIL wr_psel got %h exp 0800", o.psel); end
        nvec++; if (o.paddr !== 32'h0000_B010) begin nerr++; $display("FAIL wr_paddr got %h exp 0000b010", o.paddr); end
        nvec++; if (o.pwdata !== 32'hA5A5_0001) begin nerr++; $display("FAIL wr_pwdata got %h exp a5a50001", o.pwdata); end
        nvec++; if (o.pwrite !== 1'b1) begin nerr++; $display("FAIL wr_pwrite got %b exp 1", o.pwrite); end
        nvec++; if (o.setup_pen !== 1'b0) begin nerr++; $display("FAIL wr_setup_penable got %b exp 0", o.setup_pen); end
        nvec++; if (o.pen_cyc !== 1) begin nerr++; $display("FAIL wr_penable_cycles got %0d exp 1", o.pen_cyc); end
        nvec++; if (o.idle_pen !== 1'b0) begin nerr++; $display("FAIL wr_penable_after got %b exp 0", o.idle_pen); end
        nvec++; if (o.resp_done !== 1'b0) begin nerr++; $display("FAIL wr_hresp got %b exp 0", o.resp_done); end
        nvec++; if (o.low !== 1) begin nerr++; $display("FAIL wr_latency got %0d exp 1", o.low); end
        nvec++; if (o.idle_psel !== 16'h0) begin nerr++; $display("FAIL wr_idle_psel got %h exp 0", o.idle_psel); end
    endtask

    task automatic test_write_waits();
        obs_t o;
        logic [31:0] a, d;
        int w;
        for (int i = 0; i < 5; i++) begin
            a = {16'h0, 4'hB, 10'($urandom), 2'b00};
            d = $urandom;
            w = $urandom_range(0, 3);
            ahb_xfer(a, 1'b1, d, w, 1'b0, 32'h0, o);
            mem[a] = d;
            nvec++; if (o.psel !== 16'h0800) begin nerr++; $display("FAIL ww_psel[%0d] got %h exp 0800", i, o.psel); end
            nvec++; if (o.pwdata !== d) begin nerr++; $display("FAIL ww_pwdata[%0d] got %h exp %h", i, o.pwdata, d); end
            nvec++; if (o.low !== 1 + w) begin nerr++; $display("FAIL ww_latency[%0d] got %0d exp %0d", i, o.low, 1 + w); end
            nvec++; if (o.rdy_done !== 1'b1) begin nerr++; $display("FAIL ww_done[%0d] got %b exp 1", i, o.rdy_done); end
            nvec++; if (o.psel_stable !== 1'b1) begin nerr++; $display("FAIL ww_psel_stable[%0d] got %b exp 1", i, o.psel_stable); end
        end
    endtask

    task automatic test_read();
        obs_t o;
        ahb_xfer(32'h0000_3004, 1'b0, 32'hDEAD_0000, 2, 1'b0, 32'h1234_5678, o);
        nvec++; if (o.hrdata !== 32'h1234_5678) begin nerr++; $display("FAIL rd_hrdata got %h exp 12345678", o.hrdata); end
        nvec++; if (o.hold !== 32'h1234_5678) begin nerr++; $display("FAIL rd_hrdata_hold got %h exp 12345678", o.hold); end
        nvec++; if (o.pwrite !== 1'b0) begin nerr++; $display("FAIL rd_pwrite got %b exp 0", o.pwrite); end
        nvec++; if (o.psel !== 16'h0008) begin nerr++; $display("FAIL rd_psel got %h exp 0008", o.psel); end
        nvec++; if (o.low !== 3) begin nerr++; $display("FAIL rd_latency got %0d exp 3", o.low); end
        nvec++; if (o.pen_cyc !== 3) begin nerr++; $display("FAIL rd_penable_cycles got %0d exp 3", o.pen_cyc); end
    endtask

    task automatic test_error();
        obs_t o;
        ahb_xfer(32'h0000_7020, 1'b1, 32'h0BAD_F00D, $urandom_range(0, 2), 1'b1, 32'h0, o);
        nvec++; if (o.rdy_done !== 1'b0) begin nerr++; $display("FAIL err_done_rdy got %b exp 0", o.rdy_done); end
        nvec++; if (o.e1_resp !== 1'b1) begin nerr++; $display("FAIL err1_hresp got %b exp 1", o.e1_resp); end
        nvec++; if (o.e1_rdy !== 1'b0) begin nerr++; $display("FAIL err1_hreadyout got %b exp 0", o.e1_rdy); end
        nvec++; if (o.e2_resp !== 1'b1) begin nerr++; $display("FAIL err2_hresp got %b exp 1", o.e2_resp); end
        nvec++; if (o.e2_rdy !== 1'b1) begin nerr++; $display("FAIL err2_hreadyout got %b exp 1", o.e2_rdy); end
        nvec++; if (o.idle_psel !== 16'h0) begin nerr++; $display("FAIL err_dropped_psel got %h exp 0", o.idle_psel); end
        nvec++; if (o.idle_rdy !== 1'b1) begin nerr++; $display("FAIL err_idle_rdy got %b exp 1", o.idle_rdy); end
        nvec++; if (hresp !== 1'b0) begin nerr++; $display("FAIL err_idle_hresp got %b exp 0", hresp); end
    endtask

    task automatic test_ignored();
        int kind;
        for (int i = 0; i < 12; i++) begin
            @(negedge hclk);
            kind = $urandom_range(0, 3);
            hsel = (kind != 2);
            htrans = (kind == 0) ? 2'b01 : (kind == 1) ? 2'b00 : 2'b10;
            hrdy_lo = (kind == 3);
            haddr = $urandom; hwrite = $urandom;
            @(negedge hclk); hsel = 0; htrans = 2'b00; hrdy_lo = 0; #1;
            nvec++; if (psel !== 16'h0) begin nerr++; $display("FAIL ign_psel[%0d] kind %0d got %h exp 0", i, kind, psel); end
            nvec++; if (hreadyout !== 1'b1) begin nerr++; $display("FAIL ign_rdy[%0d] kind %0d got %b exp 1", i, kind, hreadyout); end
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] a, d, rd;
        logic wr;
        int w;
        for (int i = 0; i < 16; i++) begin
            a = {16'h0, 4'($urandom), 8'h0, 2'($urandom), 2'b00};
            wr = $urandom; d = $urandom; w = $urandom_range(0, 3);
            rd = mem.exists(a) ? mem[a] : (a ^ 32'hC0DE_0000);
            ahb_xfer(a, wr, d, w, 1'b0, rd, o);
            if (wr) mem[a] = d;
            nvec++; if (o.psel !== onehot(a)) begin nerr++; $display("FAIL rnd_psel[%0d] got %h exp %h", i, o.psel, onehot(a)); end
            nvec++; if (o.paddr !== a) begin nerr++; $display("FAIL rnd_paddr[%0d] got %h exp %h", i, o.paddr, a); end
            nvec++; if (o.pwrite !== wr) begin nerr++; $display("FAIL rnd_pwrite[%0d] got %b exp %b", i, o.pwrite, wr); end
            nvec++; if (o.low !== 1 + w) begin nerr++; $display("FAIL rnd_latency[%0d] got %0d exp %0d", i, o.low, 1 + w); end
            if (wr) begin
                nvec++; if (o.pwdata !== d) begin nerr++; $display("FAIL rnd_pwdata[%0d] got %h exp %h", i, o.pwdata, d); end
            end else begin
                nvec++; if (o.hold !== rd) begin nerr++; $display("FAIL rnd_hrdata[%0d] got %h exp %h", i, o.hold, rd); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, a2, d1, d2;
        a1 = {16'h0, 4'h2, 12'h040}; a2 = {16'h0, 4'hE, 12'h0FC};
        d1 = $urandom; d2 = $urandom;
        @(negedge hclk); hsel = 1; htrans = 2'b10; haddr = a1; hwrite = 1;
        @(negedge hclk); hsel = 0; htrans = 2'b00; hwdata = d1; #1;
        nvec++; if (psel !== onehot(a1)) begin nerr++; $display("FAIL b2b_psel1 got %h exp %h", psel, onehot(a1)); end
        @(negedge hclk); pready = 1; hsel = 1; htrans = 2'b10; haddr = a2; hwrite = 1; #1;
        nvec++; if (hreadyout !== 1'b1) begin nerr++; $display("FAIL b2b_done1 got %b exp 1", hreadyout); end
        nvec++; if (pwdata !== d1) begin nerr++; $display("FAIL b2b_pwdata1 got %h exp %h", pwdata, d1); end
        @(negedge hclk); pready = 0; hsel = 0; htrans = 2'b00; hwdata = d2; #1;
        nvec++; if (psel !== onehot(a2)) begin nerr++; $display("FAIL b2b_psel2 got %h exp %h", psel, onehot(a2)); end
        nvec++; if (penable !== 1'b0) begin nerr++; $display("FAIL b2b_setup2_pen got %b exp 0", penable); end
        nvec++; if (paddr !== a2) begin nerr++; $display("FAIL b2b_paddr2 got %h exp %h", paddr, a2); end
        nvec++; if (hreadyout !== 1'b0) begin nerr++; $display("FAIL b2b_setup2_rdy got %b exp 0", hreadyout); end
        @(negedge hclk); pready = 1; #1;
        nvec++; if (pwdata !== d2) begin nerr++; $display("FAIL b2b_pwdata2 got %h exp %h", pwdata, d2); end
        nvec++; if (hreadyout !== 1'b1) begin nerr++; $display("FAIL b2b_done2 got %b exp 1", hreadyout); end
        @(negedge hclk); pready = 0; #1;
        nvec++; if (psel !== 16'h0) begin nerr++; $display("FAIL b2b_idle_psel got %h exp 0", psel); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(negedge hclk); hsel = 1; htrans = 2'b10; haddr = 32'h0000_5008; hwrite = 1;
        @(negedge hclk); hsel = 0; htrans = 2'b00; hwdata = 32'h5555_AAAA;
        @(negedge hclk); pready = 0; #1;
        nvec++; if (penable !== 1'b1) begin nerr++; $display("FAIL rm_in_access got %b exp 1", penable); end
        #3 hreset_n = 1'b0; #1;
        nvec++; if (psel !== 16'h0) begin nerr++; $display("FAIL rm_psel got %h exp 0", psel); end
        nvec++; if (penable !== 1'b0) begin nerr++; $display("FAIL rm_penable got %b exp 0", penable); end
        nvec++; if (hreadyout !== 1'b1) begin nerr++; $display("FAIL rm_hreadyout got %b exp 1", hreadyout); end
        nvec++; if (paddr !== 32'h0) begin nerr++; $display("FAIL rm_paddr got %h exp 0", paddr); end
        nvec++; if (pwdata !== 32'h0) begin nerr++; $display("FAIL rm_pwdata got %h exp 0", pwdata); end
        @(negedge hclk); @(negedge hclk); hreset_n = 1'b1; #1;
        nvec++; if (psel !== 16'h0) begin nerr++; $display("FAIL rm_after_psel got %h exp 0", psel); end
        ahb_xfer(32'h0000_9000, 1'b1, 32'h0000_0099, 1, 1'b0, 32'h0, o);
        nvec++; if (o.psel !== 16'h0200) begin nerr++; $display("FAIL rm_recover_psel got %h exp 0200", o.psel); end
        nvec++; if (o.pwdata !== 32'h0000_0099) begin nerr++; $display("FAIL rm_recover_pwdata got %h exp 00000099", o.pwdata); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_write_waits();
        test_read();
        test_error();
        test_ignored();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1);
    end
endmodule
